// File: rtl/timekeeper_pkg.sv
// timekeeper_pkg: shared types and helpers for the timekeeping engine
package timekeeper_pkg;
  typedef enum logic [1:0] {M_CLOCK = 2'b00, M_SW = 2'b01, M_TIMER = 2'b10, M_BLANK = 2'b11} mode_e;
  typedef enum logic [1:0] {F_HH = 2'd0, F_MM = 2'd1, F_SS = 2'd2} field_e;
  typedef enum logic [1:0] {S_IDLE, S_ADJ_HH, S_ADJ_MM, S_ADJ_SS} adj_state_e;
  typedef struct packed {
    logic [5:0] hh;
    logic [5:0] mm;
    logic [5:0] ss;
    logic [6:0] cc;
  } time_t;
  localparam time_t TIME_ZERO = '0;
  function automatic logic time_is_zero(input time_t t);
    return t == TIME_ZERO;
  endfunction
endpackage

// File: rtl/hms_counter.sv
// hms_counter: hh:mm:ss.cc up/down counter with load, per-field increment and cascade wrap
module hms_counter
  import timekeeper_pkg::*;
#(
  parameter int HMOD = 24
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   en_i,
  input  logic   dir_i,
  input  logic   load_i,
  input  time_t  load_val_i,
  input  logic   inc_i,
  input  field_e inc_sel_i,
  input  logic   clr_cc_i,
  output time_t  q_o
);
  localparam logic [6:0] H_TOP = 7'(HMOD - 1);
  time_t q_q, q_d;
  logic c_ss, c_mm, c_hh;
  function automatic logic [6:0] step(input logic [6:0] v, input logic [6:0] top, input logic dn);
    return dn ? (v == '0 ? top : v - 7'd1) : (v == top ? 7'd0 : v + 7'd1);
  endfunction
  // priority load > field increment > count, so a key action always beats a same-cycle tick
  always_comb begin
    c_ss = dir_i ? q_q.cc == '0 : q_q.cc == 7'd99;
    c_mm = c_ss && (dir_i ? q_q.ss == '0 : q_q.ss == 6'd59);
    c_hh = c_mm && (dir_i ? q_q.mm == '0 : q_q.mm == 6'd59);
    q_d = q_q;
    if (load_i) q_d = load_val_i;
    else if (inc_i) begin
      q_d.hh = inc_sel_i == F_HH ? 6'(step({1'b0, q_q.hh}, H_TOP, 1'b0)) : q_q.hh;
      q_d.mm = inc_sel_i == F_MM ? 6'(step({1'b0, q_q.mm}, 7'd59, 1'b0)) : q_q.mm;
      q_d.ss = inc_sel_i == F_SS ? 6'(step({1'b0, q_q.ss}, 7'd59, 1'b0)) : q_q.ss;
    end else if (en_i) begin
      q_d.cc = step(q_q.cc, 7'd99, dir_i);
      q_d.ss = c_ss ? 6'(step({1'b0, q_q.ss}, 7'd59, dir_i)) : q_q.ss;
      q_d.mm = c_mm ? 6'(step({1'b0, q_q.mm}, 7'd59, dir_i)) : q_q.mm;
      q_d.hh = c_hh ? 6'(step({1'b0, q_q.hh}, H_TOP, dir_i)) : q_q.hh;
    end
    if (clr_cc_i) q_d.cc = '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/timekeeper_core.sv
// timekeeper_core: clock, stopwatch and countdown timer from one tick, with field adjust and alarm
module timekeeper_core
  import timekeeper_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int HOURS_MOD = 24,
  parameter int ALARM_S   = 10,
  parameter int BLINK_HZ  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       adjust,
  input  logic       key_set,
  input  logic       key_inc,
  input  logic       key_run,
  input  logic       key_clr,
  output logic [5:0] hh,
  output logic [5:0] mm,
  output logic [5:0] ss,
  output logic [6:0] cc,
  output logic [2:0] blank,
  output logic       running,
  output logic       alarm
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int BLINK_DIV = TICK_HZ / (2 * BLINK_HZ);
  localparam int ALARM_TICKS = ALARM_S * TICK_HZ;
  localparam int PW = $clog2(DIV + 1);
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam int AW = $clog2(ALARM_TICKS + 1);
  mode_e md;
  adj_state_e st_q, st_d;
  field_e sel;
  time_t clk_t, sw_t, tmr_t, disp, lap_val_q, lap_val_d, preset_q, preset_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic [AW-1:0] al_cnt_q, al_cnt_d;
  logic [3:0] key_q, key_qq, edges, act;
  logic tick, is_clk, is_sw, is_tmr, is_blank, adj_on, adj_inc, set_e, inc_e, run_e, clr_e;
  logic blink_q, blink_d, blink_end, sw_run_q, sw_run_d, lap_q, lap_d, sw_clr;
  logic tmr_run_q, tmr_run_d, tmr_zero, tmr_en, tmr_last, tmr_tgl, tmr_load;
  logic alarm_q, alarm_d, al_end;
  assign md = mode_e'(mode);
  assign {is_clk, is_sw, is_tmr, is_blank} = {md == M_CLOCK, md == M_SW, md == M_TIMER, md == M_BLANK};
  assign tick = pre_q == PW'(DIV - 1);
  assign edges = key_q & ~key_qq;
  // an edge that clears the alarm is swallowed
  assign act = alarm_q ? 4'b0000 : edges;
  assign {set_e, inc_e, run_e, clr_e} = act;
  assign adj_on = adjust && (is_clk || is_tmr);
  assign adj_inc = inc_e && adj_on && st_q != S_IDLE;
  assign sel = st_q == S_ADJ_MM ? F_MM : st_q == S_ADJ_SS ? F_SS : F_HH;
  assign blink_end = blink_cnt_q == BW'(BLINK_DIV - 1);
  assign sw_clr = clr_e && is_sw;
  assign tmr_zero = time_is_zero(tmr_t);
  assign tmr_en = tick && tmr_run_q && !(is_tmr && adjust) && !tmr_zero;
  assign tmr_last = tmr_en && tmr_t == time_t'(25'd1);
  assign tmr_tgl = run_e && is_tmr && !adjust && !tmr_zero;
  assign tmr_load = clr_e && is_tmr && !tmr_run_q;
  assign al_end = tick && al_cnt_q == AW'(ALARM_TICKS - 1);
  always_comb begin
    pre_d = tick ? '0 : pre_q + 1'b1;
    st_d = !adj_on ? S_IDLE : st_q == S_IDLE ? S_ADJ_HH : !set_e ? st_q :
           st_q == S_ADJ_HH ? S_ADJ_MM : st_q == S_ADJ_MM ? S_ADJ_SS : S_ADJ_HH;
    blink_cnt_d = (!adj_on || (tick && blink_end)) ? '0 : tick ? blink_cnt_q + 1'b1 : blink_cnt_q;
    blink_d = adj_on && (blink_q ^ (tick && blink_end));
    sw_run_d = sw_run_q ^ (run_e && is_sw);
    lap_d = sw_clr ? sw_run_q && !lap_q : lap_q;
    lap_val_d = sw_clr && sw_run_q ? sw_t : lap_val_q;
    tmr_run_d = !(tmr_last || tmr_zero) && (tmr_run_q ^ tmr_tgl);
    preset_d = st_q != S_IDLE && is_tmr ? tmr_t : preset_q;
    alarm_d = tmr_last || (alarm_q && !(|edges) && !al_end);
    al_cnt_d = !alarm_q ? '0 : tick ? al_cnt_q + 1'b1 : al_cnt_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pre_q <= '0;
      key_q <= '0;
      key_qq <= '0;
      st_q <= S_IDLE;
      blink_cnt_q <= '0;
      blink_q <= 1'b0;
      sw_run_q <= 1'b0;
      lap_q <= 1'b0;
      lap_val_q <= '0;
      tmr_run_q <= 1'b0;
      preset_q <= '0;
      alarm_q <= 1'b0;
      al_cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      key_q <= {key_set, key_inc, key_run, key_clr};
      key_qq <= key_q;
      st_q <= st_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q <= blink_d;
      sw_run_q <= sw_run_d;
      lap_q <= lap_d;
      lap_val_q <= lap_val_d;
      tmr_run_q <= tmr_run_d;
      preset_q <= preset_d;
      alarm_q <= alarm_d;
      al_cnt_q <= al_cnt_d;
    end
  hms_counter #(.HMOD(HOURS_MOD)) u_clock (
    .clk(clk), .reset(reset), .en_i(tick && !(is_clk && adjust)), .dir_i(1'b0),
    .load_i(1'b0), .load_val_i(TIME_ZERO), .inc_i(adj_inc && is_clk), .inc_sel_i(sel),
    .clr_cc_i(is_clk && adjust), .q_o(clk_t)
  );
  hms_counter #(.HMOD(24)) u_stopwatch (
    .clk(clk), .reset(reset), .en_i(tick && sw_run_q), .dir_i(1'b0),
    .load_i(sw_clr && !sw_run_q), .load_val_i(TIME_ZERO), .inc_i(1'b0), .inc_sel_i(F_HH),
    .clr_cc_i(1'b0), .q_o(sw_t)
  );
  hms_counter #(.HMOD(24)) u_timer (
    .clk(clk), .reset(reset), .en_i(tmr_en), .dir_i(1'b1),
    .load_i(tmr_load), .load_val_i(preset_q), .inc_i(adj_inc && is_tmr), .inc_sel_i(sel),
    .clr_cc_i(is_tmr && adjust), .q_o(tmr_t)
  );
  assign disp = is_clk ? clk_t : is_sw ? (lap_q ? lap_val_q : sw_t) : is_tmr ? tmr_t : TIME_ZERO;
  assign {hh, mm, ss, cc} = disp;
  assign blank = is_blank ? 3'b111 : st_q == S_IDLE ? 3'b000 :
                 {sel == F_HH, sel == F_MM, sel == F_SS} & {3{blink_q}};
  assign running = is_sw ? sw_run_q : is_tmr ? tmr_run_q : 1'b0;
  assign alarm = alarm_q;
endmodule
